coef_bank_mem: RTL and testbench
================================

# coef_bank_mem

Double-buffered, parametrised coefficient memory for the FIR datapath, successor to the single-bank 64x16 coefficient RAM. The host loads a new coefficient set into the shadow bank through a CEN/WEN/A/D/Q port while the filter streams taps from the active bank through an auto-incrementing sweep engine. A bank swap is requested by the host and committed only when no sweep is in progress, so the filter never sees a mixed coefficient set.

## Interface
- WIDTH, 16, coefficient width in bits
- DEPTH, 64, entries per bank, >= 2
- AW, clog2(DEPTH), address width (derived, not overridden)
- CLK  in  1  rising-edge clock
- RSTN  in  1  asynchronous, active-low reset
- CEN  in  1  host chip enable, active low
- WEN  in  1  host write enable, active low (0 = write, 1 = read)
- A  in  AW  host address into the shadow bank
- D  in  WIDTH  host write data
- Q  out  WIDTH  host readback data from the shadow bank
- SWAP_REQ  in  1  single-cycle swap request
- NTAPS  in  AW+1  sweep length, sampled with TAP_START
- TAP_START  in  1  single-cycle sweep start
- TAP_Q  out  WIDTH  coefficient from the active bank
- TAP_IDX  out  AW  index of TAP_Q
- TAP_VALID  out  1  TAP_Q/TAP_IDX valid this cycle
- TAP_LAST  out  1  with TAP_VALID, marks the final tap
- BUSY  out  1  sweep in progress
- SWAP_PEND  out  1  swap requested, not yet committed
- ACTIVE_BANK  out  1  bank currently read by the sweep engine

## Operation
- Two banks of DEPTH x WIDTH. Shadow bank = ~ACTIVE_BANK. Contents are not reset.
- Host port, shadow bank only:
  - CEN=0, WEN=0: write D to shadow[A]. Q holds.
  - CEN=0, WEN=1: Q <= shadow[A].
  - CEN=1: no access; Q holds.
  - A >= DEPTH: writes are dropped; reads return 0.
- Sweep FSM, states IDLE and RUN:
  - IDLE -> RUN on TAP_START=1 with NTAPS != 0. The length latched is n = min(NTAPS, DEPTH) and the counter is set to 0.
  - TAP_START with NTAPS=0 is ignored.
  - In RUN, each edge reads active[counter], presents it on TAP_Q/TAP_IDX with TAP_VALID=1, and increments the counter.
  - On the edge that reads index n-1: TAP_LAST=1 and the FSM returns to IDLE.
  - TAP_START while in RUN is ignored; it is not queued.
- Swap FSM, state is SWAP_PEND:
  - SWAP_REQ with FSM in IDLE commits at that edge: ACTIVE_BANK toggles and SWAP_PEND stays 0.
  - SWAP_REQ with FSM in RUN sets SWAP_PEND. The swap commits at the first edge where the FSM is IDLE, and SWAP_PEND clears at that same edge.
  - Repeated SWAP_REQ while pending has no extra effect; one toggle only.
- Simultaneous events:
  - SWAP_REQ (or a pending swap) and TAP_START in IDLE: the swap commits at that edge, and the sweep reads the new active bank.
  - A host write on the commit edge lands in the pre-commit shadow bank, which is the new active bank.
  - A host read on the commit edge returns pre-commit shadow data.

## Timing
- Reset values: Q=0, TAP_Q=0, TAP_IDX=0, TAP_VALID=0, TAP_LAST=0, BUSY=0, SWAP_PEND=0, ACTIVE_BANK=0, FSM=IDLE.
- Reset asserted mid-sweep aborts immediately. No further TAP_VALID, and any pending swap is discarded.
- Host read latency is 1 cycle: A is presented at edge k, and Q is valid after edge k.
- Sweep: TAP_START is sampled at edge t0. TAP_VALID is high after edges t0+1 .. t0+n, with TAP_IDX = 0 .. n-1.
- BUSY rises after edge t0 and falls after edge t0+n.
- Earliest accepted restart is edge t0+n+1, giving n+1 cycles per sweep.
- All outputs are registered. No combinational input-to-output paths.

## Test plan
- Reset check: release RSTN -> all outputs 0. Then write shadow[1]=350 and read A=1 -> Q=350 one cycle after the read edge.
- Swap and sweep: load shadow[i]=i+100 for i=0..63, SWAP_REQ in IDLE -> ACTIVE_BANK=1. Then TAP_START with NTAPS=64 -> 64 TAP_VALID cycles with TAP_Q=100..163, TAP_LAST only on idx 63, BUSY high for 64 cycles.
- Deferred swap: SWAP_REQ at the 3rd tap of an 8-tap sweep -> SWAP_PEND=1. All 8 taps come from the old bank. ACTIVE_BANK toggles one edge after TAP_LAST.
- Length rules: NTAPS=0 -> no sweep, BUSY stays 0. NTAPS=100 -> clamped to 64 taps. TAP_START asserted mid-sweep -> ignored, no extra taps.
- Commit-edge collision: SWAP_REQ together with TAP_START, plus a host write to A=5 with D=777 on the same edge -> the sweep reads the new bank, and TAP_IDX 5 returns 777.
- Mid-sweep reset: pull RSTN low during tap 10 of 32 with SWAP_PEND=1 -> TAP_VALID=0 and SWAP_PEND=0 immediately, ACTIVE_BANK=0.

Source files
------------

// File: rtl/coef_bank_mem_if.sv
// rtl/coef_bank_mem_if.sv - host port and tap stream bundle for coef_bank_mem
interface coef_bank_mem_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic             cen;
   logic             wen;
   logic [AW-1:0]    a;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             swap_req;
   logic [AW:0]      ntaps;
   logic             tap_start;
   logic [WIDTH-1:0] tap_q;
   logic [AW-1:0]    tap_idx;
   logic             tap_valid;
   logic             tap_last;
   logic             busy;
   logic             swap_pend;
   logic             active_bank;

   modport master (
      output cen, wen, a, d, swap_req, ntaps, tap_start,
      input  q, tap_q, tap_idx, tap_valid, tap_last, busy, swap_pend, active_bank
   );

   modport slave (
      input  cen, wen, a, d, swap_req, ntaps, tap_start,
      output q, tap_q, tap_idx, tap_valid, tap_last, busy, swap_pend, active_bank
   );
endinterface

// File: rtl/coef_bank_mem.sv
// rtl/coef_bank_mem.sv - double-buffered coefficient memory with tap sweep engine
// Host reads/writes the shadow bank; the sweep streams the active bank; swaps commit only when idle.
module coef_bank_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   coef_bank_mem_if.slave bus
);
   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    cnt_q;
   logic [AW:0]      len_q;
   logic [AW:0]      len_clamp;
   logic             active_q, pend_q, busy_q;
   logic [WIDTH-1:0] q_q, tap_q_q;
   logic [AW-1:0]    tap_idx_q;
   logic             tap_valid_q, tap_last_q;
   logic             start_ok, tap_fire, tap_end, commit, addr_ok;

   logic [WIDTH-1:0] mem [2][DEPTH];

   assign addr_ok   = ({1'b0, bus.a} < DEPTH_W);
   assign len_clamp = (bus.ntaps > DEPTH_W) ? DEPTH_W : bus.ntaps;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // A pending or fresh swap commits only in IDLE, before the sweep it may start samples the bank.
   always_comb begin
      state_d  = state_q;
      start_ok = 1'b0;
      tap_fire = 1'b0;
      tap_end  = 1'b0;
      commit   = 1'b0;
      case (state_q)
         IDLE: begin
            commit = bus.swap_req | pend_q;
            if (bus.tap_start && (bus.ntaps != '0)) begin
               start_ok = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            tap_fire = 1'b1;
            if ({1'b0, cnt_q} == (len_q - 1'b1)) begin
               tap_end = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Writes use the pre-commit shadow index, so a write on the commit edge lands in the new active bank.
   always_ff @(posedge clk) begin
      if (!bus.cen && !bus.wen && addr_ok)
         mem[~active_q][bus.a] <= bus.d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         len_q       <= '0;
         active_q    <= 1'b0;
         pend_q      <= 1'b0;
         busy_q      <= 1'b0;
         q_q         <= '0;
         tap_q_q     <= '0;
         tap_idx_q   <= '0;
         tap_valid_q <= 1'b0;
         tap_last_q  <= 1'b0;
      end else begin
         busy_q <= (state_d == RUN);

         if (!bus.cen && bus.wen)
            q_q <= addr_ok ? mem[~active_q][bus.a] : '0;

         if (tap_fire) begin
            tap_q_q     <= mem[active_q][cnt_q];
            tap_idx_q   <= cnt_q;
            tap_valid_q <= 1'b1;
            tap_last_q  <= tap_end;
            cnt_q       <= cnt_q + 1'b1;
         end else begin
            tap_valid_q <= 1'b0;
            tap_last_q  <= 1'b0;
         end

         if (start_ok) begin
            cnt_q <= '0;
            len_q <= len_clamp;
         end

         if (commit) begin
            active_q <= ~active_q;
            pend_q   <= 1'b0;
         end else if (bus.swap_req) begin
            pend_q   <= 1'b1;
         end
      end
   end

   assign bus.q           = q_q;
   assign bus.tap_q       = tap_q_q;
   assign bus.tap_idx     = tap_idx_q;
   assign bus.tap_valid   = tap_valid_q;
   assign bus.tap_last    = tap_last_q;
   assign bus.busy        = busy_q;
   assign bus.swap_pend   = pend_q;
   assign bus.active_bank = active_q;
endmodule

// File: tb/tb_coef_bank_mem.sv
// tb/tb_coef_bank_mem.sv - self-checking bench for coef_bank_mem
module tb_coef_bank_mem;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   coef_bank_mem_if #(.WIDTH(16), .DEPTH(64)) bus();
   coef_bank_mem #(.WIDTH(16), .DEPTH(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_chk = 0, n_pass = 0;
   int n_valid, n_busy, n_last;
   logic [15:0] cap5;

   // reference: bank arrays, a queue of tap indices still to be emitted, swap flags
   logic [15:0] mbank [2][64];
   int          tq[$];
   bit          m_act, m_pend;
   logic [15:0] e_q, e_tq;
   logic [5:0]  e_idx;
   bit          e_valid, e_last, e_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
   endtask

   task automatic model_reset();
      tq.delete();
      m_act = 0; m_pend = 0;
      e_q = 0; e_tq = 0; e_idx = 0; e_valid = 0; e_last = 0; e_busy = 0;
   endtask

   task automatic compare_all();
      check("q", bus.q, e_q);
      check("active_bank", bus.active_bank, e_act_w());
      check("swap_pend", bus.swap_pend, e_pend_w());
      check("busy", bus.busy, e_busy);
      check("tap_valid", bus.tap_valid, e_valid);
      check("tap_last", bus.tap_last, e_last);
      if (e_valid) begin
         check("tap_q", bus.tap_q, e_tq);
         check("tap_idx", bus.tap_idx, e_idx);
      end
   endtask

   function automatic logic e_act_w();  return m_act;  endfunction
   function automatic logic e_pend_w(); return m_pend; endfunction

   task automatic idle_in();
      bus.cen = 1; bus.wen = 1; bus.a = 0; bus.d = 0;
      bus.swap_req = 0; bus.tap_start = 0; bus.ntaps = 0;
   endtask

   task automatic step();
      bit idle;
      int idx, lim;
      if (!rst_n) model_reset();
      else begin
         idle = (tq.size() == 0);
         if (!bus.cen && bus.wen) e_q = mbank[!m_act][bus.a];
         if (!idle) begin
            idx     = tq.pop_front();
            e_tq    = mbank[m_act][idx];
            e_idx   = idx[5:0];
            e_valid = 1;
            e_last  = (tq.size() == 0);
         end else begin
            e_valid = 0;
            e_last  = 0;
         end
         if (!bus.cen && !bus.wen) mbank[!m_act][bus.a] = bus.d;
         if (idle && (bus.swap_req || m_pend)) begin
            m_act  = !m_act;
            m_pend = 0;
         end else if (bus.swap_req) m_pend = 1;
         if (idle && bus.tap_start && bus.ntaps != 0) begin
            lim = (bus.ntaps > 64) ? 64 : int'(bus.ntaps);
            for (int i = 0; i < lim; i++) tq.push_back(i);
         end
         e_busy = (tq.size() != 0);
      end
      @(posedge clk);
      #1;
      compare_all();
      if (bus.tap_valid) n_valid++;
      if (bus.busy) n_busy++;
      if (bus.tap_last) n_last++;
      if (bus.tap_valid && bus.tap_idx == 6'd5) cap5 = bus.tap_q;
   endtask

   task automatic hwrite(input int addr, input int data);
      bus.cen = 0; bus.wen = 0; bus.a = addr[5:0]; bus.d = data[15:0];
      step();
      idle_in();
   endtask

   task automatic hread(input int addr);
      bus.cen = 0; bus.wen = 1; bus.a = addr[5:0];
      step();
      idle_in();
   endtask

   task automatic start(input int n);
      bus.tap_start = 1; bus.ntaps = n[6:0];
      step();
      idle_in();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clr_cnt();
      n_valid = 0; n_busy = 0; n_last = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 70 && tq.size() != 0; i++) step();
      step();
   endtask

   initial begin
      logic act0;
      rst_n = 0;
      idle_in();
      model_reset();
      steps(2);
      check("rst_tap_q", bus.tap_q, 0);
      check("rst_tap_idx", bus.tap_idx, 0);
      #2 rst_n = 1;

      hwrite(1, 350);
      hread(1);
      check("q_350", bus.q, 350);

      for (int i = 0; i < 64; i++) hwrite(i, i + 100);
      bus.swap_req = 1; step(); idle_in();
      check("swap_idle_active", bus.active_bank, 1);

      clr_cnt();
      start(64);
      steps(64);
      check("sweep64_valid", n_valid, 64);
      check("sweep64_busy", n_busy, 64);
      check("sweep64_last", n_last, 1);
      step();

      for (int i = 0; i < 64; i++) hwrite(i, $urandom_range(0, 65535));

      act0 = bus.active_bank;
      start(8);
      steps(2);
      bus.swap_req = 1; step(); idle_in();
      check("defer_pend", bus.swap_pend, 1);
      steps(4);
      bus.swap_req = 1; step(); idle_in();
      check("defer_last", bus.tap_last, 1);
      check("defer_hold", bus.active_bank, act0);
      step();
      check("defer_toggle", bus.active_bank, !act0);
      check("defer_pend_clr", bus.swap_pend, 0);

      clr_cnt();
      start(0);
      steps(3);
      check("ntaps0_busy", n_busy, 0);
      clr_cnt();
      start(100);
      steps(66);
      check("clamp_valid", n_valid, 64);
      clr_cnt();
      start(10);
      steps(3);
      start(20);
      steps(10);
      check("restart_ignored", n_valid, 10);

      cap5 = 0;
      bus.swap_req = 1; bus.tap_start = 1; bus.ntaps = 8;
      bus.cen = 0; bus.wen = 0; bus.a = 5; bus.d = 777;
      step(); idle_in();
      steps(9);
      check("collide_idx5", cap5, 777);

      for (int i = 0; i < 400; i++) begin
         bus.cen       = ($urandom_range(0, 1) == 0);
         bus.wen       = ($urandom_range(0, 1) == 0);
         bus.a         = 6'($urandom_range(0, 63));
         bus.d         = 16'($urandom_range(0, 65535));
         bus.swap_req  = ($urandom_range(0, 7) == 0);
         bus.tap_start = ($urandom_range(0, 5) == 0);
         bus.ntaps     = 7'($urandom_range(0, 127));
         step();
      end
      idle_in();
      drain();

      start(32);
      steps(2);
      bus.swap_req = 1; step(); idle_in();
      steps(7);
      check("pre_rst_idx9", bus.tap_idx, 9);
      check("pre_rst_pend", bus.swap_pend, 1);
      #2 rst_n = 0;
      #1;
      model_reset();
      check("rst_mid_valid", bus.tap_valid, 0);
      check("rst_mid_pend", bus.swap_pend, 0);
      check("rst_mid_active", bus.active_bank, 0);
      check("rst_mid_busy", bus.busy, 0);
      clr_cnt();
      steps(2);
      #2 rst_n = 1;
      steps(4);
      check("post_rst_no_taps", n_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
